// File: rtl/fir_out_requant.sv
// FIR output stage: decimate, round/saturate to a narrower format, and buffer in a FIFO.
// Optional FIR_REQUANT_SAT_CNT_EN adds a saturating 16-bit count of saturated samples.
module fir_out_requant #(
  parameter int unsigned IN_INTE_WL  = 4,
  parameter int unsigned IN_FRAC_WL  = 8,
  parameter int unsigned OUT_INTE_WL = 2,
  parameter int unsigned OUT_FRAC_WL = 6,
  parameter int unsigned DECIM       = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ROUND_MODE  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [IN_INTE_WL+IN_FRAC_WL-1:0]   in_data,
  input  logic                               in_valid,
  output logic [OUT_INTE_WL+OUT_FRAC_WL-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               sat_flag,
  output logic                               overflow,
  input  logic                               clear_ovf
`ifdef FIR_REQUANT_SAT_CNT_EN
  ,
  output logic [15:0]                        sat_count
`endif
);

  localparam int IW = int'(IN_INTE_WL + IN_FRAC_WL);
  localparam int OW = int'(OUT_INTE_WL + OUT_FRAC_WL);
  localparam int SH = int'(IN_FRAC_WL) - int'(OUT_FRAC_WL);
  // Two guard bits cover the rounding carry; extra bits hold a left shift.
  localparam int XW = IW + 2 + ((SH < 0) ? -SH : 0);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic signed [XW-1:0] MAXV = XW'(2 ** (OW - 1) - 1);
  localparam logic signed [XW-1:0] MINV = ~MAXV;

  // Decimation counter
  logic [DW-1:0] dcnt;
  logic          keep;

  assign keep = in_valid && (dcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
    end else if (in_valid) begin
      dcnt <= (dcnt == DW'(DECIM - 1)) ? '0 : dcnt + DW'(1);
    end
  end

  // Requantization
  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] scaled;
  logic [OW-1:0]        qdata;
  logic                 qsat;

  assign ext = {{(XW - IW){in_data[IW-1]}}, in_data};

  if (SH > 0) begin : g_shr
    logic signed [XW-1:0] rnd;
    assign rnd    = (ROUND_MODE != 0) ? ext + (XW'(1) << (SH - 1)) : ext;
    assign scaled = rnd >>> SH;
  end else begin : g_shl
    assign scaled = ext <<< (-SH);
  end

  always_comb begin
    qdata = scaled[OW-1:0];
    qsat  = 1'b0;
    if (scaled > MAXV) begin
      qdata = MAXV[OW-1:0];
      qsat  = 1'b1;
    end else if (scaled < MINV) begin
      qdata = MINV[OW-1:0];
      qsat  = 1'b1;
    end
  end

  // Pipe stage
  logic [OW-1:0] pipe_data;
  logic          pipe_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_data  <= '0;
      pipe_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      pipe_data  <= qdata;
      pipe_valid <= keep;
      sat_flag   <= keep && qsat;
    end
  end

  // FIFO
  logic [OW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          drop;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  // A pop frees the head slot this cycle, so a full FIFO can still accept.
  assign push      = pipe_valid && ((count < (AW+1)'(FIFO_DEPTH)) || pop);
  assign drop      = pipe_valid && !push;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pipe_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef FIR_REQUANT_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (clear_ovf) begin
      sat_count <= {15'd0, sat_flag};
    end else if (sat_flag && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule
